// File: rtl/wave_seq_pkg.sv
// Shared types and reset defaults for the wave step sequencer.
// Optional debug ports are enabled with WAVE_SEQ_DEBUG_EN.
package wave_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_DUR = 10;

    function automatic logic def_level(input int idx);
        return ~idx[0];
    endfunction

endpackage

// File: rtl/wave_seq_if.sv
// Host-side configuration, control and status bundle for the sequencer.
// Master is the host, slave is wave_seq_ctrl.
interface wave_seq_if #(
    parameter int STEPS = 4,
    parameter int CNT_W = 5,
    parameter int REP_W = 4
);
    localparam int AW = $clog2(STEPS);

    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic             cfg_level;
    logic [CNT_W-1:0] cfg_dur;
    logic [AW-1:0]    last_step;
    logic [REP_W-1:0] repeat_cnt;
    logic             start;
    logic             stop;
    logic             q;
    logic             busy;
    logic             done;
    logic             cfg_err;

    modport master (
        output cfg_we, cfg_addr, cfg_level, cfg_dur,
        output last_step, repeat_cnt, start, stop,
        input  q, busy, done, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_level, cfg_dur,
        input  last_step, repeat_cnt, start, stop,
        output q, busy, done, cfg_err
    );

endinterface

// File: rtl/wave_seq_ctrl_table.sv
// Step table: STEPS x (level, duration) registers, reset to the legacy
// 1/0/1/0 waveform, synchronous write, combinational read.
module wave_step_table
    import wave_seq_pkg::*;
#(
    parameter int STEPS = 4,
    parameter int CNT_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(STEPS)-1:0] waddr,
    input  logic                     wlevel,
    input  logic [CNT_W-1:0]         wdur,
    input  logic [$clog2(STEPS)-1:0] raddr,
    output logic [STEPS-1:0]         level,
    output logic [CNT_W-1:0]         rdur
);

    logic [CNT_W-1:0] dur [STEPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) begin
                level[i] <= def_level(i);
                dur[i]   <= CNT_W'(DEF_DUR);
            end
        end else if (we) begin
            level[waddr] <= wlevel;
            dur[waddr]   <= wdur;
        end
    end

    assign rdur = dur[raddr];

endmodule

// File: rtl/wave_seq_ctrl.sv
// Programmable step sequencer driving a single-bit waveform.
// WAVE_SEQ_DEBUG_EN exposes step/cnt/pass registers as dbg_* outputs.
module wave_seq_ctrl
    import wave_seq_pkg::*;
#(
    parameter int STEPS = 4,
    parameter int CNT_W = 5,
    parameter int REP_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    wave_seq_if.slave bus
`ifdef WAVE_SEQ_DEBUG_EN
    ,
    output logic [$clog2(STEPS)-1:0] dbg_step,
    output logic [CNT_W-1:0]         dbg_cnt,
    output logic [REP_W-1:0]         dbg_pass
`endif
);

    localparam int AW = $clog2(STEPS);

    state_e           state, state_d;
    logic [AW-1:0]    step, step_d;
    logic [AW-1:0]    last_l, last_d;
    logic [AW-1:0]    nxt;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [REP_W-1:0] pass, pass_d;
    logic [REP_W-1:0] rep_l, rep_d;
    logic             q, q_d;
    logic             done, done_d;
    logic             cfg_err;
    logic [STEPS-1:0] lvl;
    logic [CNT_W-1:0] dur;

    wave_step_table #(
        .STEPS (STEPS),
        .CNT_W (CNT_W)
    ) u_table (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (bus.cfg_we && state == IDLE),
        .waddr  (bus.cfg_addr),
        .wlevel (bus.cfg_level),
        .wdur   (bus.cfg_dur),
        .raddr  (step),
        .level  (lvl),
        .rdur   (dur)
    );

    assign nxt = step + AW'(1);

    always_comb begin
        state_d = state;
        step_d  = step;
        last_d  = last_l;
        cnt_d   = cnt;
        pass_d  = pass;
        rep_d   = rep_l;
        q_d     = q;
        done_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = RUN;
                    last_d  = bus.last_step;
                    rep_d   = bus.repeat_cnt;
                    step_d  = '0;
                    cnt_d   = '0;
                    pass_d  = REP_W'(1);
                    q_d     = lvl[0];
                end
            end
            RUN: begin
                // stop outranks every step/pass transition
                if (bus.stop) begin
                    state_d = IDLE;
                    q_d     = 1'b0;
                end else if (cnt != dur) begin
                    cnt_d = cnt + CNT_W'(1);
                end else if (step != last_l) begin
                    cnt_d  = '0;
                    step_d = nxt;
                    q_d    = lvl[nxt];
                end else if (rep_l != '0 && pass == rep_l) begin
                    state_d = IDLE;
                    q_d     = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    step_d = '0;
                    cnt_d  = '0;
                    q_d    = lvl[0];
                    if (pass != '1) pass_d = pass + REP_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            step    <= '0;
            last_l  <= '0;
            cnt     <= '0;
            pass    <= '0;
            rep_l   <= '0;
            q       <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_d;
            step    <= step_d;
            last_l  <= last_d;
            cnt     <= cnt_d;
            pass    <= pass_d;
            rep_l   <= rep_d;
            q       <= q_d;
            done    <= done_d;
            cfg_err <= bus.cfg_we && state == RUN;
        end
    end

    assign bus.q       = q;
    assign bus.busy    = (state == RUN);
    assign bus.done    = done;
    assign bus.cfg_err = cfg_err;

`ifdef WAVE_SEQ_DEBUG_EN
    assign dbg_step = step;
    assign dbg_cnt  = cnt;
    assign dbg_pass = pass;
`endif

endmodule
